// File: rtl/tdc_meas_ctrl_pkg.sv
// Shared types and width helpers for the multi-sample TDC measurement controller.
package tdc_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_ACQ, ST_DONE} tdc_meas_st_t;
    typedef enum logic {ENC_POP, ENC_THERM} tdc_enc_t;

    // Encoded sample width: must hold the value N itself
    function automatic int unsigned hw_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

    function automatic int unsigned al_width(input int unsigned max_al);
        return $clog2(max_al + 1);
    endfunction

endpackage

// File: rtl/tdc_meas_ctrl_enc.sv
// Combinational delay-line word encoder: popcount or bubble-tolerant thermometer.
module tdc_word_enc
    import tdc_pkg::*;
#(
    parameter int unsigned N    = 64,
    parameter int unsigned HW_W = hw_width(N)
) (
    input  logic [N-1:0]    capt_in,
    input  tdc_enc_t        mode,
    output logic [HW_W-1:0] enc_c
);

    logic [HW_W-1:0] pop;
    logic [HW_W-1:0] therm;
    logic            run;

    // run stays high only while the ones are unbroken from bit 0, so bubbles are ignored
    always_comb begin
        pop   = '0;
        therm = '0;
        run   = 1'b1;
        for (int unsigned i = 0; i < N; i++) begin
            pop   = pop + HW_W'(capt_in[i]);
            run   = run & capt_in[i];
            therm = therm + HW_W'(run);
        end
        enc_c = (mode == ENC_THERM) ? therm : pop;
    end

endmodule

// File: rtl/tdc_meas_ctrl.sv
// Multi-sample TDC measurement controller: accumulates 2^avg_log2 encoded samples per
// request and returns sum/mean/min/max over a valid/ready interface.
module tdc_meas_ctrl
    import tdc_pkg::*;
#(
    parameter  int unsigned N            = 64,
    parameter  int unsigned MAX_AVG_LOG2 = 8,
    localparam int unsigned HW_W         = hw_width(N),
    localparam int unsigned SUM_W        = HW_W + MAX_AVG_LOG2,
    localparam int unsigned AL_W         = al_width(MAX_AVG_LOG2)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              start,
    input  logic              abort,
    input  logic              mode,
    input  logic [AL_W-1:0]   avg_log2,
    input  logic [N-1:0]      capt_in,
    input  logic              capt_vld,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [SUM_W-1:0]  res_sum,
    output logic [HW_W-1:0]   res_mean,
    output logic [HW_W-1:0]   res_min,
    output logic [HW_W-1:0]   res_max
);

    localparam int unsigned CNT_W = MAX_AVG_LOG2;

    tdc_meas_st_t     state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [AL_W-1:0]  al_q, al_nxt;
    tdc_enc_t         mode_q, mode_nxt;
    logic [SUM_W-1:0] sum_q, sum_nxt;
    logic [HW_W-1:0]  mean_q, mean_nxt;
    logic [HW_W-1:0]  min_q, min_nxt;
    logic [HW_W-1:0]  max_q, max_nxt;
    logic             busy_q, valid_q;
    logic [HW_W-1:0]  enc_c;
    logic [AL_W-1:0]  al_clamp_c;
    logic             last_c;

    tdc_word_enc #(.N(N), .HW_W(HW_W)) u_enc (
        .capt_in (capt_in),
        .mode    (mode_q),
        .enc_c   (enc_c)
    );

    assign al_clamp_c = (avg_log2 > AL_W'(MAX_AVG_LOG2)) ? AL_W'(MAX_AVG_LOG2) : avg_log2;
    assign last_c     = (cnt_q == CNT_W'((32'd1 << al_q) - 32'd1));

    // Next-state and datapath; en low freezes everything, abort outranks sample and handshake
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        al_nxt    = al_q;
        mode_nxt  = mode_q;
        sum_nxt   = sum_q;
        mean_nxt  = mean_q;
        min_nxt   = min_q;
        max_nxt   = max_q;
        if (en) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_nxt = ST_ACQ;
                        cnt_nxt   = '0;
                        al_nxt    = al_clamp_c;
                        mode_nxt  = tdc_enc_t'(mode);
                        sum_nxt   = '0;
                        min_nxt   = HW_W'(N);
                        max_nxt   = '0;
                    end
                end
                ST_ACQ: begin
                    if (abort) begin
                        state_nxt = ST_IDLE;
                    end else if (capt_vld) begin
                        sum_nxt = sum_q + SUM_W'(enc_c);
                        min_nxt = (enc_c < min_q) ? enc_c : min_q;
                        max_nxt = (enc_c > max_q) ? enc_c : max_q;
                        cnt_nxt = cnt_q + CNT_W'(1);
                        if (last_c) begin
                            state_nxt = ST_DONE;
                            mean_nxt  = HW_W'(sum_nxt >> al_q);
                        end
                    end
                end
                ST_DONE: begin
                    if (abort || res_ready) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            al_q    <= '0;
            mode_q  <= ENC_POP;
            sum_q   <= '0;
            mean_q  <= '0;
            min_q   <= HW_W'(N);
            max_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            al_q    <= al_nxt;
            mode_q  <= mode_nxt;
            sum_q   <= sum_nxt;
            mean_q  <= mean_nxt;
            min_q   <= min_nxt;
            max_q   <= max_nxt;
            busy_q  <= (state_nxt != ST_IDLE);
            valid_q <= (state_nxt == ST_DONE);
        end
    end

    assign busy      = busy_q;
    assign res_valid = valid_q;
    assign res_sum   = sum_q;
    assign res_mean  = mean_q;
    assign res_min   = min_q;
    assign res_max   = max_q;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Scoreboard bench for tdc_meas_ctrl: expected results queued at stimulus, compared at handshake.
module tb_tdc_meas_ctrl;

    localparam int unsigned N     = 64;
    localparam int unsigned HW_W  = 7;
    localparam int unsigned SUM_W = 15;
    localparam int unsigned AL_W  = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             mode = 1'b0;
    logic [AL_W-1:0]  avg_log2 = '0;
    logic [N-1:0]     capt_in = '0;
    logic             capt_vld = 1'b0;
    logic             busy;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [SUM_W-1:0] res_sum;
    logic [HW_W-1:0]  res_mean;
    logic [HW_W-1:0]  res_min;
    logic [HW_W-1:0]  res_max;

    typedef struct {
        int sum;
        int mean;
        int mn;
        int mx;
    } exp_t;

    exp_t         exp_q[$];
    logic [N-1:0] stim[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           n_pop   = 0;

    tdc_meas_ctrl #(.N(64), .MAX_AVG_LOG2(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .start     (start),
        .abort     (abort),
        .mode      (mode),
        .avg_log2  (avg_log2),
        .capt_in   (capt_in),
        .capt_vld  (capt_vld),
        .busy      (busy),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_mean  (res_mean),
        .res_min   (res_min),
        .res_max   (res_max)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int enc_model(input bit m, input logic [N-1:0] w);
        int k;
        if (!m) return $countones(w);
        k = 0;
        while (k < 64 && w[k]) k++;
        return k;
    endfunction

    function automatic logic [N-1:0] ones(input int k);
        logic [N-1:0] w;
        w = '0;
        for (int i = 0; i < k; i++) w[i] = 1'b1;
        return w;
    endfunction

    function automatic exp_t model(input bit m, input int nsamp);
        exp_t e;
        int   v;
        int   al;
        al = $clog2(nsamp);
        e.sum = 0; e.mn = 64; e.mx = 0;
        for (int i = 0; i < nsamp; i++) begin
            v = enc_model(m, stim[i]);
            e.sum += v;
            if (v < e.mn) e.mn = v;
            if (v > e.mx) e.mx = v;
        end
        e.mean = e.sum >> al;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare on every accepted result; any valid with nothing expected is an error
    always @(negedge clk) begin
        if (rst_n && res_valid && exp_q.size() == 0)
            check("spurious_valid", 1, 0);
        else if (rst_n && res_valid && res_ready && en) begin
            check("sb_sum",  res_sum,  exp_q[0].sum);
            check("sb_mean", res_mean, exp_q[0].mean);
            check("sb_min",  res_min,  exp_q[0].mn);
            check("sb_max",  res_max,  exp_q[0].mx);
            void'(exp_q.pop_front());
            n_pop++;
        end
    end

    // Run one measurement from stim[]; leaves the DUT in DONE
    task automatic do_meas(input bit m, input logic [AL_W-1:0] al);
        int nsamp;
        nsamp = 1 << ((al > 8) ? 8 : int'(al));
        exp_q.push_back(model(m, nsamp));
        start = 1'b1; mode = m; avg_log2 = al;
        step();
        start = 1'b0; mode = ~m; avg_log2 = '0;
        check("busy_after_start", busy, 1);
        for (int i = 0; i < nsamp; i++) begin
            capt_in = stim[i]; capt_vld = 1'b1;
            step();
            if (i == nsamp - 2) check("valid_early", res_valid, 0);
        end
        capt_vld = 1'b0;
        check("valid_latency", res_valid, 1);
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("idle_after_hs", busy, 0);
        check("valid_after_hs", res_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        step();
        check("rst_busy", busy, 0);
        check("rst_valid", res_valid, 0);
        check("rst_sum", res_sum, 0);
        check("rst_mean", res_mean, 0);
        check("rst_min", res_min, 64);
        check("rst_max", res_max, 0);
        rst_n = 1'b1;
        step();

        // popcount, 4 samples
        stim = '{ones(8), ones(16), ones(24), ones(32)};
        do_meas(1'b0, 4'd2);
        handshake();

        // thermometer with a bubble, single sample
        stim = '{64'h0000_0000_0000_F0FF};
        do_meas(1'b1, 4'd0);
        check("therm_sum_direct", res_sum, 8);
        handshake();

        // 256 all-ones samples
        stim.delete();
        for (int i = 0; i < 256; i++) stim.push_back(ones(64));
        do_meas(1'b0, 4'd8);
        check("full_sum_direct", res_sum, 16384);
        handshake();

        // avg_log2 above max clamps to 256 random samples
        stim.delete();
        for (int i = 0; i < 256; i++) stim.push_back({$urandom(), $urandom()});
        do_meas(1'b0, 4'd15);
        handshake();

        // backpressure with start pulses in DONE
        stim = '{64'h00FF_0000_0FFF_FFFF, ones(12)};
        do_meas(1'b1, 4'd1);
        for (int i = 0; i < 10; i++) begin
            start = 1'b1;
            step();
            check("bp_valid", res_valid, 1);
            check("bp_sum", res_sum, exp_q[0].sum);
            check("bp_mean", res_mean, exp_q[0].mean);
        end
        res_ready = 1'b1;
        step();
        start = 1'b0; res_ready = 1'b0;
        check("start_in_hs_ignored", busy, 0);
        step();
        check("still_idle", busy, 0);

        // abort after 2 of 4 samples, abort beats a coincident sample
        start = 1'b1; avg_log2 = 4'd2; mode = 1'b0;
        step();
        start = 1'b0;
        capt_in = ones(50); capt_vld = 1'b1;
        step(); step();
        abort = 1'b1;
        step();
        abort = 1'b0; capt_vld = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", res_valid, 0);
        stim = '{ones(5), ones(5), ones(5), ones(5)};
        do_meas(1'b0, 4'd2);
        handshake();

        // en low mid-ACQ with capt_vld high, then en low blocks the handshake
        stim = '{ones(3), ones(7), ones(1), ones(9)};
        exp_q.push_back(model(1'b0, 4));
        start = 1'b1; avg_log2 = 4'd2; mode = 1'b0;
        step();
        start = 1'b0;
        capt_in = stim[0]; capt_vld = 1'b1;
        step();
        en = 1'b0; capt_in = ones(60);
        step(); step(); step();
        en = 1'b1;
        for (int i = 1; i < 4; i++) begin
            capt_in = stim[i];
            step();
            if (i == 2) check("en_no_count", res_valid, 0);
        end
        capt_vld = 1'b0;
        check("en_valid", res_valid, 1);
        en = 1'b0; res_ready = 1'b1;
        step();
        check("en_hs_blocked", res_valid, 1);
        en = 1'b1;
        step();
        res_ready = 1'b0;
        check("en_hs_done", res_valid, 0);

        // async reset mid-ACQ
        start = 1'b1; avg_log2 = 4'd2;
        step();
        start = 1'b0; capt_in = ones(10); capt_vld = 1'b1;
        step(); step();
        capt_vld = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_sum", res_sum, 0);
        check("arst_min", res_min, 64);
        check("arst_max", res_max, 0);
        step();
        rst_n = 1'b1;
        step(); step();
        check("arst_no_result", res_valid, 0);

        check("sb_empty", exp_q.size(), 0);
        check("sb_pops", n_pop, 7);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
